// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: FETCH -> WAIT_MEM -> EXEC, minimum 3 cycles per instruction.
// Memory backpressure via imem_req/imem_ack (request held until ack); execute completion via exec_done pulse.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic [31:0] instr_ID,
  input  logic [31:0] br_out,
  input  logic        exec_done,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, WAIT_MEM, EXEC, HALTED} state_t;

  state_t      state;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic        is_rel_br;
  logic        is_abs_jmp;
  logic        is_jal;

  // IDs 15-20 are pc-relative (br_out = 0 means not taken), 21-23 absolute.
  always_comb begin
    pc_inc     = pc + 32'd1;
    is_rel_br  = (instr_ID >= 32'd15) && (instr_ID <= 32'd20);
    is_abs_jmp = (instr_ID >= 32'd21) && (instr_ID <= 32'd23);
    is_jal     = (instr_ID == 32'd23);
    next_pc    = pc_inc;
    if (is_rel_br) begin
      next_pc = pc_inc + br_out;
    end else if (is_abs_jmp) begin
      next_pc = br_out;
    end
  end

  assign imem_addr = pc;
  assign link_addr = LINK_REG;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      link_we   <= 1'b0;
      link_data <= 32'd0;
      halted    <= 1'b0;
    end else begin
      link_we <= 1'b0;
      case (state)
        FETCH: begin
          if (halt) begin
            state    <= HALTED;
            halted   <= 1'b1;
            imem_req <= 1'b0;
          end else begin
            state    <= WAIT_MEM;
            imem_req <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc       <= next_pc;
            ir_valid <= 1'b0;
            if (is_jal) begin
              link_we   <= 1'b1;
              link_data <= pc_inc;
            end
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit; acts as instruction memory and execute stage.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] instr_ID;
  logic [31:0] br_out;
  logic        exec_done;
  logic        halt;
  logic [31:0] pc;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        halted;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] mpc;
  logic [31:0] last_ir;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .instr_ID(instr_ID), .br_out(br_out),
    .exec_done(exec_done), .halt(halt), .pc(pc),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Next-pc rule: relative branch adds the offset to pc+1, jumps replace pc.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] id,
                                           input logic [31:0] br);
    if (id >= 15 && id <= 20) return p + 32'd1 + br;
    if (id >= 21 && id <= 23) return br;
    return p + 32'd1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0;
    tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_link_we", link_we, 1'b0);
    chk("rst_link_data", link_data, 32'd0);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
    mpc = RESET_PC;
    last_ir = 32'd0;
  endtask

  task automatic run_instr(input logic [31:0] id, input logic [31:0] br, input int stall,
                           input int exdly, input bit hlt, input bit rst_jal);
    int n;
    logic [31:0] rd;
    bit exp_link;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    chk("req_seen", imem_req, 1'b1);
    chk("imem_addr", imem_addr, mpc);
    for (int i = 0; i < stall; i++) begin
      imem_ack  = 1'b0;
      exec_done = 1'($urandom % 2);
      instr_ID  = 32'd21;
      br_out    = $urandom;
      tick();
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, mpc);
      chk("stall_ir", ir, last_ir);
      chk("stall_pc", pc, mpc);
    end
    exec_done  = 1'b0;
    rd         = $urandom;
    imem_ack   = 1'b1;
    imem_rdata = rd;
    tick();
    imem_ack = 1'b0;
    last_ir  = rd;
    chk("ir_capture", ir, rd);
    chk("ir_valid_set", ir_valid, 1'b1);
    chk("req_drop", imem_req, 1'b0);
    instr_ID = id;
    br_out   = br;
    for (int i = 0; i < exdly; i++) begin
      imem_ack   = 1'($urandom % 2);
      imem_rdata = $urandom;
      tick();
      chk("exec_pc_hold", pc, mpc);
      chk("exec_ir_hold", ir, rd);
      chk("exec_link_we", link_we, 1'b0);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    halt      = hlt;
    if (rst_jal) rst_n = 1'b0;
    tick();
    exec_done = 1'b0;
    halt      = 1'b0;
    if (rst_jal) begin
      rst_n   = 1'b1;
      mpc     = RESET_PC;
      last_ir = 32'd0;
      chk("rstjal_link_we", link_we, 1'b0);
      chk("rstjal_pc", pc, RESET_PC);
      chk("rstjal_ir_valid", ir_valid, 1'b0);
      chk("rstjal_ir", ir, 32'd0);
    end else begin
      exp_link = (id == 32'd23);
      if (exp_link) begin
        chk("link_data", link_data, mpc + 32'd1);
        chk("link_addr", link_addr, 32'd31);
      end
      mpc = ref_next(mpc, id, br);
      chk("next_pc", pc, mpc);
      chk("ir_valid_clr", ir_valid, 1'b0);
      chk("link_we", link_we, exp_link);
      chk("halted", halted, hlt);
    end
    tick();
    chk("link_we_pulse", link_we, 1'b0);
    chk("req_after", imem_req, !hlt);
  endtask

  initial begin
    logic [31:0] id;
    logic [31:0] br;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ID = 32'd0;
    br_out = 32'd0; exec_done = 1'b0; halt = 1'b0;

    // Halt sampled in FETCH: no request, absorbing.
    do_reset();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("fetch_halt_halted", halted, 1'b1);
    chk("fetch_halt_req", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'(i % 2); exec_done = 1'b1;
      tick();
      chk("halted_req", imem_req, 1'b0);
      chk("halted_pc", pc, RESET_PC);
    end
    exec_done = 1'b0; imem_ack = 1'b0;

    // Reset in the middle of a memory handshake.
    do_reset();
    tick();
    chk("wm_req", imem_req, 1'b1);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("wm_rst_ir", ir, 32'd0);
    chk("wm_rst_ir_valid", ir_valid, 1'b0);
    chk("wm_rst_req", imem_req, 1'b0);
    chk("wm_rst_pc", pc, RESET_PC);
    rst_n = 1'b1; imem_ack = 1'b0;

    for (int i = 0; i < 4; i++) run_instr(32'd1, 32'd0, 0, 0, 1'b0, 1'b0);
    run_instr(32'd21, 32'd5, 0, 0, 1'b0, 1'b0);
    run_instr(32'd15, 32'd10, 0, 1, 1'b0, 1'b0);
    run_instr(32'd21, 32'd5, 0, 0, 1'b0, 1'b0);
    run_instr(32'd15, 32'd0, 0, 0, 1'b0, 1'b0);
    run_instr(32'd21, 32'd20, 0, 0, 1'b0, 1'b0);
    run_instr(32'd16, 32'hFFFFFFF6, 0, 0, 1'b0, 1'b0);
    run_instr(32'd21, 32'd7, 0, 0, 1'b0, 1'b0);
    run_instr(32'd21, 32'd100, 0, 0, 1'b0, 1'b0);
    run_instr(32'd21, 32'd8, 0, 0, 1'b0, 1'b0);
    run_instr(32'd23, 32'd1000, 0, 2, 1'b0, 1'b0);
    run_instr(32'd1, 32'd0, 5, 0, 1'b0, 1'b0);
    run_instr(32'd17, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    run_instr(32'd23, 32'd500, 1, 1, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      id = 32'($urandom_range(0, 30));
      if (id >= 15 && id <= 20)
        br = ($urandom % 3 == 0) ? 32'd0 : 32'($urandom_range(0, 64)) - 32'd32;
      else
        br = $urandom;
      run_instr(id, br, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    // Wrap at 2^32 combined with halt on the retire edge.
    run_instr(32'd21, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    run_instr(32'd1, 32'd0, 0, 0, 1'b1, 1'b0);
    chk("wrap_pc", pc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'(i % 2);
      tick();
      chk("post_halt_req", imem_req, 1'b0);
      chk("post_halt_halted", halted, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage that sits directly downstream of the branch resolution block.
- Fetches instruction words from instruction memory over a req/ack handshake and presents IR to decode/execute.
- Consumes the resolved branch value and the decoded instruction ID, computes the next PC, and issues the jal link-register write.
- PC is word-addressed; one PC increment equals one instruction.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- LINK_REG, 31, register index written by jal (ID 23).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has valid data this cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  instruction register presented to decode.
- ir_valid  out  1  ir holds a fetched, not-yet-retired instruction.
- instr_ID  in  32  decoded instruction ID for the current ir.
- br_out  in  32  branch block result: relative offset for IDs 15-20 (0 = not taken), absolute target for IDs 21-23.
- exec_done  in  1  one-cycle pulse; execute has finished and br_out/instr_ID are stable.
- halt  in  1  stop fetching after the current instruction retires.
- pc  out  32  current program counter.
- link_we  out  1  one-cycle register-file write enable for jal.
- link_addr  out  5  always LINK_REG.
- link_data  out  32  pc+1 of the jal instruction.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, link_we=0, link_data=0, halted=0, state=FETCH. Reset overrides every other input, including mid-handshake; no link write may escape.
- FSM states: FETCH, WAIT_MEM, EXEC, HALTED.
- FETCH: drive imem_req=1 with imem_addr=pc.
  - halt=1 -> HALTED, no request issued.
  - Otherwise -> WAIT_MEM.
- WAIT_MEM: hold imem_req=1 and imem_addr stable until imem_ack=1.
  - On ack: ir<=imem_rdata, ir_valid<=1, imem_req<=0, -> EXEC.
  - imem_ack is ignored in every other state.
- EXEC: wait for exec_done; ir and pc are held. On exec_done, compute next_pc from instr_ID:
  - IDs 15-20: next_pc = pc + 1 + br_out.
  - IDs 21-23: next_pc = br_out.
  - Any other ID: next_pc = pc + 1.
  - Then pc<=next_pc, ir_valid<=0. Go to HALTED if halt=1 on that edge, else FETCH.
- jal (ID 23): on the exec_done edge, link_we<=1 for exactly one cycle with link_data = old pc + 1.
- Arithmetic: 32-bit modulo 2^32. br_out is two's-complement for relative branches, so 0xFFFFFFFF+1 wraps to 0 and negative offsets work.
- Self-loop: beq taken with br_out = 0xFFFFFFFF gives next_pc = pc.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT_MEM with same-cycle ack, EXEC with same-cycle exec_done).
- exec_done outside EXEC: ignored.
- halt sampled only in FETCH and on the exec_done edge. HALTED is absorbing until reset; outputs hold, halted=1, imem_req=0.

Test Plan:
- Sequential fetch: reset, imem_ack immediate, 4 non-branch IDs (e.g. ID 1) -> pc goes 0,1,2,3,4; imem_addr matches pc; ir_valid pulses once per instruction.
- Conditional taken/not-taken: pc=5, ID 15, br_out=10 -> pc=16. Same with br_out=0 -> pc=6. pc=20, ID 16, br_out=0xFFFFFFF6 (-10) -> pc=11.
- Jumps: pc=7, ID 21, br_out=100 -> pc=100, link_we stays 0. pc=8, ID 23, br_out=1000 -> pc=1000, single link_we pulse, link_addr=31, link_data=9.
- Memory stall: imem_ack held low 5 cycles -> imem_req and imem_addr stable throughout, ir unchanged; ir captured on the ack cycle only.
- Reset mid-operation: assert rst_n=0 in WAIT_MEM, and separately on a jal exec_done edge -> pc=RESET_PC, link_we=0, state FETCH next cycle.
- Halt and wrap: pc=0xFFFFFFFF, ID 1, exec_done with halt=1 -> pc=0, halted=1, no further imem_req despite imem_ack toggling.
